// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and the active-low segment decoder used by
// the seven-segment receive checker.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg_dec_t;

  // Anything outside the eleven known patterns decodes with valid=0, blank=0.
  function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
    seg_dec_t r;
    r = '0;
    case (seg)
      SEG_0:     begin r.valid = 1'b1; r.digit = 4'd0; end
      SEG_1:     begin r.valid = 1'b1; r.digit = 4'd1; end
      SEG_2:     begin r.valid = 1'b1; r.digit = 4'd2; end
      SEG_3:     begin r.valid = 1'b1; r.digit = 4'd3; end
      SEG_4:     begin r.valid = 1'b1; r.digit = 4'd4; end
      SEG_5:     begin r.valid = 1'b1; r.digit = 4'd5; end
      SEG_6:     begin r.valid = 1'b1; r.digit = 4'd6; end
      SEG_7:     begin r.valid = 1'b1; r.digit = 4'd7; end
      SEG_8:     begin r.valid = 1'b1; r.digit = 4'd8; end
      SEG_9:     begin r.valid = 1'b1; r.digit = 4'd9; end
      SEG_BLANK: r.blank = 1'b1;
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_rx_checker_if.sv
// Bus between the seven-segment source (master) and the receive checker (slave).
interface seg7_rx_checker_if #(
  parameter int ERR_W = 8
);

  logic             en;
  logic [6:0]       seg_n;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             blank;
  logic             invalid;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en,
    output seg_n,
    input  digit,
    input  digit_valid,
    input  blank,
    input  invalid,
    input  seq_err,
    input  err_count
  );

  modport slave (
    input  en,
    input  seg_n,
    output digit,
    output digit_valid,
    output blank,
    output invalid,
    output seq_err,
    output err_count
  );

endinterface

// File: rtl/seg7_stable_filter.sv
// Registers the segment bus and counts how long it has held the same value;
// stable_o rises on the edge where the pattern has lasted STABLE_CYCLES samples.
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clr_i,
  input  logic [6:0] seg_i,
  output logic       changed_o,
  output logic       stable_o
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] THRESH  = 4'(STABLE_CYCLES - 2);

  logic [6:0] seg_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign changed_o = (seg_i != seg_q);
  // Accept on the edge that would take the count to STABLE_CYCLES-1.
  assign stable_o  = !changed_o && (cnt_q >= THRESH);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || changed_o) begin
      cnt_d = 4'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    seg_q <= seg_i;
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_rx_checker.sv
// Decodes a settled active-low seven-segment pattern back to BCD and flags
// digits that break the (prev+1) mod 10 incrementer sequence.
module seg7_rx_checker
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input logic              clk,
  input logic              rst,
  seg7_rx_checker_if.slave bus
);

  logic             changed;
  logic             stable;
  seg_dec_t         dec;
  logic             new_pat;
  logic             seq_hit;

  state_t           state_q;
  logic [6:0]       acc_pat_q;
  logic             acc_valid_q;
  logic [3:0]       prev_q;
  logic             has_prev_q;
  logic [3:0]       digit_q;
  logic             digit_valid_q;
  logic             blank_q;
  logic             invalid_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_q;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .clr_i    (rst || !bus.en),
    .seg_i    (bus.seg_n),
    .changed_o(changed),
    .stable_o (stable)
  );

  assign dec     = seg_to_bcd(bus.seg_n);
  // Re-settling onto the pattern already reported is not a new event.
  assign new_pat = !acc_valid_q || (bus.seg_n != acc_pat_q);
  assign seq_hit = has_prev_q && (dec.digit != next_digit(prev_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_pat_q     <= '0;
      acc_valid_q   <= 1'b0;
      prev_q        <= '0;
      has_prev_q    <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      err_q         <= '0;
    end else if (!bus.en) begin
      state_q       <= IDLE;
      acc_pat_q     <= '0;
      acc_valid_q   <= 1'b0;
      prev_q        <= '0;
      has_prev_q    <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      digit_valid_q <= 1'b0;
      invalid_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      case (state_q)
        IDLE: state_q <= SETTLE;
        SETTLE: begin
          if (stable) begin
            state_q <= LOCKED;
            if (new_pat) begin
              acc_pat_q   <= bus.seg_n;
              acc_valid_q <= 1'b1;
              if (dec.valid) begin
                digit_q       <= dec.digit;
                digit_valid_q <= 1'b1;
                blank_q       <= 1'b0;
                seq_err_q     <= seq_hit;
                prev_q        <= dec.digit;
                has_prev_q    <= 1'b1;
                if (seq_hit && (err_q != '1)) begin
                  err_q <= err_q + 1'b1;
                end
              end else if (dec.blank) begin
                blank_q <= 1'b1;
              end else begin
                invalid_q  <= 1'b1;
                blank_q    <= 1'b0;
                has_prev_q <= 1'b0;
                if (err_q != '1) begin
                  err_q <= err_q + 1'b1;
                end
              end
            end
          end
        end
        LOCKED: begin
          if (changed) begin
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.blank       = blank_q;
  assign bus.invalid     = invalid_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.err_count   = err_q;

endmodule

// File: doc/seg7_rx_checker.md
Name: seg7_rx_checker

Overview:
- Receive-side counterpart of the incrementer + seven-segment display decoder path: samples an active-low 7-segment bus, waits for the pattern to be stable, and decodes it back to a 4-bit BCD digit.
- Checks that successive accepted digits follow the incrementer sequence: (prev+1) mod 10.
- Sits on the FPGA loopback/self-test path between the display decoder outputs and the status LEDs/UART logger.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 2..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  enable; low forces IDLE
- seg_n  input  7  segments {a,b,c,d,e,f,g} = seg_n[6:0], active-low (0 = lit)
- digit  output  4  last accepted BCD digit
- digit_valid  output  1  one-cycle pulse when a new digit is accepted
- blank  output  1  level; high while the accepted pattern is all-off (7'h7F)
- invalid  output  1  one-cycle pulse when a stable, non-decodable pattern is accepted
- seq_err  output  1  one-cycle pulse, coincident with digit_valid, when the digit is not (prev+1) mod 10
- err_count  output  ERR_W  saturating count of invalid plus seq_err events

Behaviour:
- Decode table for seg_n (hex): 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, blank=7F. Any other value is invalid.
- Reset, or en=0 on any edge: all outputs 0 (digit=0, err_count=0 on rst only). State goes to IDLE. Stability counter cleared. Sequence reference cleared (has_prev=0). The en=0 path retains err_count.
- Input register: seg_q <= seg_n on every edge. stab_cnt resets to 0 when seg_n != seg_q, otherwise increments and saturates at STABLE_CYCLES.
- State machine:
  - IDLE -> SETTLE when en=1.
  - SETTLE: when stab_cnt reaches STABLE_CYCLES-1 with seg_n==seg_q, accept the pattern and go to LOCKED.
  - LOCKED: holds while the pattern is unchanged. Any change returns to SETTLE, and all pulse outputs stay low meanwhile.
- Latency: if seg_n first takes value P before edge k and holds, the accept pulses are high in the cycle after edge k+STABLE_CYCLES-1. A glitch shorter than STABLE_CYCLES cycles produces no event.
- Re-accepting the same pattern after a glitch back to it: no event. acc_pat stores the last accepted pattern, and acceptance of a pattern equal to acc_pat is suppressed.
- On accepting a valid digit D:
  - digit<=D, digit_valid pulse, blank<=0.
  - If has_prev and D != (prev+1) mod 10: seq_err pulse.
  - Then prev<=D, has_prev<=1.
  - Wrap 9->0 is legal.
- On accepting blank: blank<=1. digit and prev unchanged. No pulse. has_prev kept, so blanking between digits is not an error.
- On accepting invalid: invalid pulse, has_prev<=0, digit unchanged, blank<=0.
- err_count: +1 per invalid or seq_err event, saturating at all-ones. Never wraps.
- Reset mid-SETTLE: pending pattern discarded. No pulse is issued for it.

Decomposition:
- Package seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK localparams.
  - State enum {IDLE, SETTLE, LOCKED}.
  - Pure function seg_to_bcd returning {valid, blank, digit}.
- One sub-module, seg7_stable_filter: the seg_q/stab_cnt logic with a "stable" output, parameterised by STABLE_CYCLES.
- Top level holds the FSM, the sequence checker and err_count.

Test Plan:
- rst=1 for 2 cycles, then en=1 with seg_n=7F held -> after STABLE_CYCLES+1 edges blank=1, no digit_valid, err_count=0.
- Drive 01,4F,12,...,04,01 (0..9..0), each held 6 cycles -> 11 digit_valid pulses with digit 0..9,0 and no seq_err; the 9->0 wrap is accepted.
- Hold 4F (1), glitch to 12 for 2 cycles, return to 4F -> no pulses at all.
- Drive 06 (3) then 24 (5) -> digit_valid and seq_err pulse together with digit=5, err_count=1.
- Drive 7E (invalid) for 6 cycles, then 4C (4) -> invalid pulse, err_count+1, then 4 accepted with no seq_err (reference cleared).
- With ERR_W=2, force 5 seq errors -> err_count saturates at 3. Assert rst mid-SETTLE -> no pulse and all outputs 0 on the next edge.
